pes_vedic_mul16_seq: RTL

Sequential 16x16 multiplier controller that time-shares one `pes_vedic_mul` (8x8 Vedic) datapath instance across four partial-product steps and accumulates them into a 32-bit result. It sits between a valid/ready operand source and a valid/ready result sink and owns the operand-half muxing, shift alignment and accumulation. It is used where area matters more than throughput: one 8x8 multiplier instead of four.

---
 rtl/pes_vedic_mul16_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pes_vedic_mul16_seq.sv
// Area-lean 16x16 multiplier: one 8x8 Vedic core time-shared over four partial-product steps.
// Define VEDIC_SEQ_SIGNED_EN for two's-complement operands (sign/magnitude around the unsigned core).

module pes_vedic_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 2x2 Urdhva-Tiryagbhyam cell
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    c = x[1] & y[0] & x[0] & y[1];
    return {x[1] & y[1] & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] mid;
    mid = 8'(vm2(x[3:2], y[1:0])) + 8'(vm2(x[1:0], y[3:2]));
    return 8'(vm2(x[1:0], y[1:0])) + (mid << 2) + (8'(vm2(x[3:2], y[3:2])) << 4);
  endfunction

  logic [15:0] mid8;

  always_comb begin
    mid8 = 16'(vm4(a[7:4], b[3:0])) + 16'(vm4(a[3:0], b[7:4]));
    p    = 16'(vm4(a[3:0], b[3:0])) + (mid8 << 4) + (16'(vm4(a[7:4], b[7:4])) << 8);
  end

endmodule

module pes_vedic_mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod,
  output logic        busy
);

  localparam int unsigned OW = 16;
  localparam int unsigned PW = 32;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      step_q;
  logic [OW-1:0]   a_q, b_q;
  logic [PW-1:0]   acc_q, aligned, sum;
  logic [7:0]      op_a, op_b;
  logic [15:0]     pp;
  logic            accept;

  assign accept = (state_q == IDLE) && in_valid;
  assign prod   = acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (step_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags registered from the next-state decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Step 1 picks b high, step 2 picks a high, step 3 both high
  assign op_a = step_q[1] ? a_q[15:8] : a_q[7:0];
  assign op_b = step_q[0] ? b_q[15:8] : b_q[7:0];

  pes_vedic_mul u_core (
    .a (op_a),
    .b (op_b),
    .p (pp)
  );

  always_comb begin
    aligned = PW'(pp);
    case (step_q)
      2'd1, 2'd2: aligned = PW'(pp) << 8;
      2'd3:       aligned = PW'(pp) << 16;
      default:    aligned = PW'(pp);
    endcase
    sum = acc_q + aligned;
  end

`ifdef VEDIC_SEQ_SIGNED_EN
  logic          sign_q;
  logic [OW-1:0] a_mag, b_mag;

  // 16-bit negate maps 0x8000 onto itself, which is the correct unsigned magnitude
  assign a_mag = a[15] ? OW'(-a) : a;
  assign b_mag = b[15] ? OW'(-b) : b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; acc_q <= '0; step_q <= 2'd0; sign_q <= 1'b0;
    end else if (accept) begin
      a_q <= a_mag; b_q <= b_mag; acc_q <= '0; step_q <= 2'd0; sign_q <= a[15] ^ b[15];
    end else if (state_q == MUL) begin
      step_q <= step_q + 2'd1;
      acc_q  <= (step_q == 2'd3 && sign_q) ? PW'(-sum) : sum;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; acc_q <= '0; step_q <= 2'd0;
    end else if (accept) begin
      a_q <= a; b_q <= b; acc_q <= '0; step_q <= 2'd0;
    end else if (state_q == MUL) begin
      step_q <= step_q + 2'd1;
      acc_q  <= sum;
    end
  end
`endif

endmodule
